mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- LINE_BITS, 128, cache line width
- LADDR, 10, line address width
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports, one per line: name, direction, width, meaning:
- clk, in, 1, clock
- rst, in, 1, async active-high reset
- Ic_mem_req, in, 1, I-cache line fill request; level, held until F_mem_valid
- Ic_mem_addr, in, LADDR, I-fill line address
- Dc_mem_req, in, 1, D-cache line fill request; level, held until MEM_mem_valid
- Dc_mem_addr, in, LADDR, D-fill line address
- Dc_wb_we, in, 1, D-cache write-back request; level, held until Dc_wb_ack
- Dc_wb_addr, in, LADDR, write-back line address
- Dc_wb_wline, in, LINE_BITS, write-back line data
- F_mem_inst, out, LINE_BITS, I-fill line data
- F_mem_valid, out, 1, I-fill done pulse
- MEM_data_line, out, LINE_BITS, D-fill line data
- MEM_mem_valid, out, 1, D-fill done pulse
- Dc_wb_ack, out, 1, write-back done pulse
- Bk_req, out, 1, backing memory command strobe
- Bk_we, out, 1, command is write
- Bk_addr, out, LADDR, command line address
- Bk_wline, out, LINE_BITS, write data
- Bk_rline, in, LINE_BITS, read data, valid with Bk_valid
- Bk_valid, in, 1, backing memory completion pulse

Function
REQ-003 The block SHALL serialize I-fills, D-fills and D-write-backs onto a single-port backing memory, one transaction outstanding at a time.
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-005 IDLE: if any request is pending, latch grant, address, write data and Bk_we, then go to ISSUE; otherwise remain in IDLE.
REQ-006 Grant priority SHALL be: write-back first, then D-fill and I-fill alternated round-robin via a last_grant bit. When only one of the two is pending, it wins.
REQ-007 last_grant SHALL update only on D-fill or I-fill grants, never on write-back grants.
REQ-008 ISSUE: Bk_req=1 for exactly this one cycle with the latched Bk_we/Bk_addr/Bk_wline. Go to DONE if Bk_valid=1 this cycle, else to WAIT.
REQ-009 WAIT: hold Bk_we/Bk_addr/Bk_wline and keep Bk_req=0; on Bk_valid=1 go to DONE.
REQ-010 On the Bk_valid cycle of a read, Bk_rline SHALL be registered into F_mem_inst (I grant) or MEM_data_line (D grant) only.
REQ-011 DONE: assert exactly one of F_mem_valid / MEM_mem_valid / Dc_wb_ack for one cycle, per the grant; next state IDLE.
REQ-012 Requests SHALL NOT be sampled in ISSUE, WAIT or DONE; the requester drops its request on seeing its done pulse.
REQ-013 Latency: request first seen in IDLE at cycle T with backing latency L (Bk_valid L cycles after Bk_req) gives the done pulse at T+L+2; the minimum is T+2 when L=0.
REQ-014 F_mem_inst and MEM_data_line SHALL hold their value until the next fill of the same type.
REQ-015 Bk_valid arriving in IDLE or DONE SHALL be ignored (stale after reset).
REQ-016 Address and data inputs SHALL be sampled only at grant; later changes SHALL NOT affect the transaction in flight.

Reset
REQ-017 On rst=1, asynchronously: state=IDLE, last_grant=I (so D wins the first tie), and all outputs plus latched address/data registers = 0.
REQ-018 Reset mid-transaction SHALL abort it with no done pulse. The requester re-issues after reset.

Verification
REQ-019 I-fill, L=3: Ic_mem_req=1, addr=0x005 at T → Bk_req=1, Bk_we=0, Bk_addr=0x005 at T+1; Bk_valid at T+4 with Bk_rline=0xA5..A5 → F_mem_valid=1 at T+5, F_mem_inst=0xA5..A5 held afterwards.
REQ-020 Simultaneous requests: Dc_wb_we (addr 0x010), Dc_mem_req (0x011) and Ic_mem_req (0x002) all at T → grant order WB, D, I; Bk_addr sequence 0x010, 0x011, 0x002; Dc_wb_ack precedes MEM_mem_valid, which precedes F_mem_valid.
REQ-021 Round-robin: Dc_mem_req and Ic_mem_req held continuously and re-asserted one cycle after each done pulse → grants alternate D, I, D, I; no side waits more than one transaction.
REQ-022 Write-back data capture: Dc_wb_wline=0x1234_..., then changed in the cycle after grant → Bk_wline still shows the original value in ISSUE and WAIT; Dc_wb_ack pulses once.
REQ-023 Reset mid-WAIT: D-fill in WAIT, rst pulsed, then Bk_valid arrives after reset → no MEM_mem_valid, MEM_data_line=0, state IDLE.
REQ-024 L=0: Bk_valid in the ISSUE cycle → done pulse at T+2 with the correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Serialises I-cache fills, D-cache fills and D-cache write-backs onto a
// single-port backing memory, one transaction in flight at a time.
module mem_arbiter #(
  parameter int LINE_BITS = 128,
  parameter int LADDR     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Ic_mem_req,
  input  logic [LADDR-1:0]     Ic_mem_addr,
  input  logic                 Dc_mem_req,
  input  logic [LADDR-1:0]     Dc_mem_addr,
  input  logic                 Dc_wb_we,
  input  logic [LADDR-1:0]     Dc_wb_addr,
  input  logic [LINE_BITS-1:0] Dc_wb_wline,
  output logic [LINE_BITS-1:0] F_mem_inst,
  output logic                 F_mem_valid,
  output logic [LINE_BITS-1:0] MEM_data_line,
  output logic                 MEM_mem_valid,
  output logic                 Dc_wb_ack,
  output logic                 Bk_req,
  output logic                 Bk_we,
  output logic [LADDR-1:0]     Bk_addr,
  output logic [LINE_BITS-1:0] Bk_wline,
  input  logic [LINE_BITS-1:0] Bk_rline,
  input  logic                 Bk_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_WB, G_D, G_I} grant_t;

  state_t               state_q;
  grant_t               grant_q;
  grant_t               grant_d;
  logic                 last_d_q;   // 1: last fill grant went to the D side
  logic                 bk_req_q;
  logic                 bk_we_q;
  logic [LADDR-1:0]     bk_addr_q;
  logic [LINE_BITS-1:0] bk_wline_q;
  logic [LINE_BITS-1:0] f_inst_q;
  logic [LINE_BITS-1:0] mem_line_q;
  logic                 f_valid_q;
  logic                 mem_valid_q;
  logic                 wb_ack_q;

  // Write-back always wins; the two fill sides share round-robin on ties.
  always_comb begin
    grant_d = G_NONE;
    if (Dc_wb_we)                     grant_d = G_WB;
    else if (Dc_mem_req && Ic_mem_req) grant_d = last_d_q ? G_I : G_D;
    else if (Dc_mem_req)              grant_d = G_D;
    else if (Ic_mem_req)              grant_d = G_I;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= G_NONE;
      last_d_q    <= 1'b0;
      bk_req_q    <= 1'b0;
      bk_we_q     <= 1'b0;
      bk_addr_q   <= '0;
      bk_wline_q  <= '0;
      f_inst_q    <= '0;
      mem_line_q  <= '0;
      f_valid_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_ack_q    <= 1'b0;
    end else begin
      bk_req_q    <= 1'b0;
      f_valid_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_ack_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d != G_NONE) begin
            grant_q  <= grant_d;
            bk_req_q <= 1'b1;
            bk_we_q  <= (grant_d == G_WB);
            state_q  <= ISSUE;
            case (grant_d)
              G_WB: begin
                bk_addr_q  <= Dc_wb_addr;
                bk_wline_q <= Dc_wb_wline;
              end
              G_D: begin
                bk_addr_q  <= Dc_mem_addr;
                bk_wline_q <= '0;
                last_d_q   <= 1'b1;
              end
              default: begin
                bk_addr_q  <= Ic_mem_addr;
                bk_wline_q <= '0;
                last_d_q   <= 1'b0;
              end
            endcase
          end
        end
        ISSUE, WAIT: begin
          if (Bk_valid) begin
            state_q <= DONE;
            case (grant_q)
              G_I: begin
                f_inst_q  <= Bk_rline;
                f_valid_q <= 1'b1;
              end
              G_D: begin
                mem_line_q  <= Bk_rline;
                mem_valid_q <= 1'b1;
              end
              default: wb_ack_q <= 1'b1;
            endcase
          end else begin
            state_q <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Bk_req        = bk_req_q;
  assign Bk_we         = bk_we_q;
  assign Bk_addr       = bk_addr_q;
  assign Bk_wline      = bk_wline_q;
  assign F_mem_inst    = f_inst_q;
  assign F_mem_valid   = f_valid_q;
  assign MEM_data_line = mem_line_q;
  assign MEM_mem_valid = mem_valid_q;
  assign Dc_wb_ack     = wb_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled on the
// falling edge; a small responder process plays the backing memory.
module tb_mem_arbiter;
  localparam int LB = 128;
  localparam int LA = 10;

  logic          clk, rst;
  logic          Ic_mem_req, Dc_mem_req, Dc_wb_we;
  logic [LA-1:0] Ic_mem_addr, Dc_mem_addr, Dc_wb_addr;
  logic [LB-1:0] Dc_wb_wline;
  logic [LB-1:0] F_mem_inst, MEM_data_line, Bk_wline, Bk_rline;
  logic          F_mem_valid, MEM_mem_valid, Dc_wb_ack, Bk_req, Bk_we, Bk_valid;
  logic [LA-1:0] Bk_addr;

  int vec = 0;
  int err = 0;

  int            bk_lat;
  logic [LB-1:0] bk_data;
  bit            resp_en;
  logic          resp_valid, man_valid;
  logic [LB-1:0] resp_rline, man_rline;
  logic [LA-1:0] log_addr[$];
  logic          log_we[$];
  logic [LB-1:0] log_wline[$];
  logic [LB-1:0] exp_f, exp_m;

  assign Bk_valid = resp_valid | man_valid;
  assign Bk_rline = man_valid ? man_rline : resp_rline;

  mem_arbiter #(.LINE_BITS(LB), .LADDR(LA)) dut (
    .clk(clk), .rst(rst),
    .Ic_mem_req(Ic_mem_req), .Ic_mem_addr(Ic_mem_addr),
    .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
    .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
    .F_mem_inst(F_mem_inst), .F_mem_valid(F_mem_valid),
    .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_ack(Dc_wb_ack),
    .Bk_req(Bk_req), .Bk_we(Bk_we), .Bk_addr(Bk_addr), .Bk_wline(Bk_wline),
    .Bk_rline(Bk_rline), .Bk_valid(Bk_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: answers each Bk_req strobe bk_lat cycles later.
  initial begin
    resp_valid = 1'b0;
    resp_rline = '0;
    forever begin
      @(negedge clk);
      if (resp_en && Bk_req) begin
        log_addr.push_back(Bk_addr);
        log_we.push_back(Bk_we);
        log_wline.push_back(Bk_wline);
        if (bk_lat > 0) repeat (bk_lat) @(negedge clk);
        resp_valid = 1'b1;
        resp_rline = bk_data;
        @(negedge clk);
        resp_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wline.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (Bk_req !== 1'b0) begin err++; $display("FAIL rst_bk_req got=%0b exp=0", Bk_req); end
    vec++; if (Bk_we !== 1'b0) begin err++; $display("FAIL rst_bk_we got=%0b exp=0", Bk_we); end
    vec++; if (Bk_addr !== '0) begin err++; $display("FAIL rst_bk_addr got=%0h exp=0", Bk_addr); end
    vec++; if (Bk_wline !== '0) begin err++; $display("FAIL rst_bk_wline got=%0h exp=0", Bk_wline); end
    vec++; if (F_mem_inst !== '0) begin err++; $display("FAIL rst_f_inst got=%0h exp=0", F_mem_inst); end
    vec++; if (MEM_data_line !== '0) begin err++; $display("FAIL rst_mem_line got=%0h exp=0", MEM_data_line); end
    vec++; if ({F_mem_valid, MEM_mem_valid, Dc_wb_ack} !== 3'b000) begin
      err++; $display("FAIL rst_pulses got=%b exp=000", {F_mem_valid, MEM_mem_valid, Dc_wb_ack});
    end
    rst = 1'b0;
    @(negedge clk);
    vec++; if (Bk_req !== 1'b0) begin err++; $display("FAIL idle_no_req got=%0b exp=0", Bk_req); end
    exp_f = '0;
    exp_m = '0;
  endtask

  task automatic test_ifill();
    int done_at;
    logic [1:0] others;
    bk_lat = 3; bk_data = {16{8'hA5}}; resp_en = 1'b1; clear_log();
    Ic_mem_req = 1'b1; Ic_mem_addr = 10'h005;
    @(negedge clk);
    vec++; if ({Bk_req, Bk_we} !== 2'b10) begin err++; $display("FAIL ifill_issue req/we got=%b exp=10", {Bk_req, Bk_we}); end
    vec++; if (Bk_addr !== 10'h005) begin err++; $display("FAIL ifill_issue_addr got=%0h exp=5", Bk_addr); end
    Ic_mem_addr = 10'h3AA;
    @(negedge clk);
    vec++; if (Bk_req !== 1'b0) begin err++; $display("FAIL ifill_wait_req got=%0b exp=0", Bk_req); end
    vec++; if (Bk_addr !== 10'h005) begin err++; $display("FAIL ifill_wait_addr got=%0h exp=5", Bk_addr); end
    done_at = -1; others = 2'b00;
    for (int i = 3; i <= 12; i++) begin
      @(negedge clk);
      if (F_mem_valid) begin done_at = i; others = {MEM_mem_valid, Dc_wb_ack}; break; end
    end
    vec++; if (done_at !== 5) begin err++; $display("FAIL ifill_latency got=%0d exp=5", done_at); end
    vec++; if (others !== 2'b00) begin err++; $display("FAIL ifill_other_pulses got=%b exp=00", others); end
    vec++; if (F_mem_inst !== {16{8'hA5}}) begin err++; $display("FAIL ifill_data got=%0h exp=a5..", F_mem_inst); end
    Ic_mem_req = 1'b0;
    @(negedge clk);
    vec++; if (F_mem_valid !== 1'b0) begin err++; $display("FAIL ifill_pulse_width got=%0b exp=0", F_mem_valid); end
    vec++; if (F_mem_inst !== {16{8'hA5}}) begin err++; $display("FAIL ifill_hold got=%0h exp=a5..", F_mem_inst); end
    exp_f = {16{8'hA5}};
  endtask

  task automatic test_priority();
    int order[3];
    int n, dup;
    logic [LA-1:0] ea[3];
    logic          ew[3];
    logic [LA-1:0] ga;
    logic          gw;
    bk_lat = 1; bk_data = {16{8'h3C}}; clear_log();
    ea[0] = 10'h010; ea[1] = 10'h011; ea[2] = 10'h002;
    ew[0] = 1'b1;    ew[1] = 1'b0;    ew[2] = 1'b0;
    Dc_wb_we = 1'b1; Dc_wb_addr = 10'h010; Dc_wb_wline = {8{16'hBEEF}};
    Dc_mem_req = 1'b1; Dc_mem_addr = 10'h011;
    Ic_mem_req = 1'b1; Ic_mem_addr = 10'h002;
    order = '{-1, -1, -1}; n = 0; dup = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (int'(Dc_wb_ack) + int'(MEM_mem_valid) + int'(F_mem_valid) > 1) dup++;
      if (Dc_wb_ack)     begin order[n] = 0; n++; Dc_wb_we = 1'b0; end
      if (MEM_mem_valid) begin order[n] = 1; n++; Dc_mem_req = 1'b0; end
      if (F_mem_valid)   begin order[n] = 2; n++; Ic_mem_req = 1'b0; end
    end
    for (int k = 0; k < 3; k++) begin
      vec++; if (order[k] !== k) begin err++; $display("FAIL prio_order[%0d] got=%0d exp=%0d", k, order[k], k); end
      ga = (k < log_addr.size()) ? log_addr[k] : 'x;
      gw = (k < log_we.size()) ? log_we[k] : 1'bx;
      vec++; if (ga !== ea[k]) begin err++; $display("FAIL prio_addr[%0d] got=%0h exp=%0h", k, ga, ea[k]); end
      vec++; if (gw !== ew[k]) begin err++; $display("FAIL prio_we[%0d] got=%0b exp=%0b", k, gw, ew[k]); end
    end
    vec++; if (dup !== 0) begin err++; $display("FAIL prio_overlap got=%0d exp=0", dup); end
    vec++; if (log_wline.size() < 1 || log_wline[0] !== {8{16'hBEEF}}) begin
      err++; $display("FAIL prio_wb_wline size=%0d exp=beef..", log_wline.size());
    end
    exp_f = {16{8'h3C}}; exp_m = {16{8'h3C}};
    vec++; if (MEM_data_line !== exp_m) begin err++; $display("FAIL prio_mem_line got=%0h exp=%0h", MEM_data_line, exp_m); end
  endtask

  task automatic test_round_robin();
    int n;
    bit d_re, i_re;
    logic [LA-1:0] ea[4];
    logic [LA-1:0] ga;
    bk_lat = 2; bk_data = {16{8'h77}}; clear_log();
    ea[0] = 10'h021; ea[1] = 10'h032; ea[2] = 10'h021; ea[3] = 10'h032;
    Dc_mem_addr = 10'h021; Ic_mem_addr = 10'h032;
    Dc_mem_req = 1'b1; Ic_mem_req = 1'b1;
    n = 0; d_re = 1'b0; i_re = 1'b0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (d_re) begin Dc_mem_req = 1'b1; d_re = 1'b0; end
      if (i_re) begin Ic_mem_req = 1'b1; i_re = 1'b0; end
      if (MEM_mem_valid) begin Dc_mem_req = 1'b0; d_re = 1'b1; n++; end
      if (F_mem_valid)   begin Ic_mem_req = 1'b0; i_re = 1'b1; n++; end
    end
    Dc_mem_req = 1'b0; Ic_mem_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ga = (k < log_addr.size()) ? log_addr[k] : 'x;
      vec++; if (ga !== ea[k]) begin err++; $display("FAIL rr_grant[%0d] got=%0h exp=%0h", k, ga, ea[k]); end
    end
    repeat (4) @(negedge clk);
    vec++; if (log_addr.size() !== 4) begin err++; $display("FAIL rr_extra_grant got=%0d exp=4", log_addr.size()); end
    exp_f = {16{8'h77}}; exp_m = {16{8'h77}};
    vec++; if (F_mem_inst !== exp_f) begin err++; $display("FAIL rr_f_inst got=%0h exp=%0h", F_mem_inst, exp_f); end
  endtask

  task automatic test_wb_capture();
    logic [LB-1:0] orig;
    int acks;
    bk_lat = 2; bk_data = {16{8'hEE}}; clear_log();
    orig = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    Dc_wb_wline = orig; Dc_wb_addr = 10'h3FF; Dc_wb_we = 1'b1;
    @(negedge clk);
    Dc_wb_wline = ~orig; Dc_wb_addr = 10'h000;
    vec++; if ({Bk_req, Bk_we} !== 2'b11) begin err++; $display("FAIL wb_issue req/we got=%b exp=11", {Bk_req, Bk_we}); end
    vec++; if (Bk_addr !== 10'h3FF) begin err++; $display("FAIL wb_issue_addr got=%0h exp=3ff", Bk_addr); end
    vec++; if (Bk_wline !== orig) begin err++; $display("FAIL wb_issue_wline got=%0h exp=%0h", Bk_wline, orig); end
    @(negedge clk);
    vec++; if ({Bk_req, Bk_we} !== 2'b01) begin err++; $display("FAIL wb_wait req/we got=%b exp=01", {Bk_req, Bk_we}); end
    vec++; if (Bk_wline !== orig) begin err++; $display("FAIL wb_wait_wline got=%0h exp=%0h", Bk_wline, orig); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Dc_wb_ack) begin acks++; Dc_wb_we = 1'b0; end
    end
    Dc_wb_we = 1'b0;
    vec++; if (acks !== 1) begin err++; $display("FAIL wb_ack_count got=%0d exp=1", acks); end
    vec++; if (MEM_data_line !== exp_m) begin err++; $display("FAIL wb_mem_line_kept got=%0h exp=%0h", MEM_data_line, exp_m); end
    vec++; if (F_mem_inst !== exp_f) begin err++; $display("FAIL wb_f_inst_kept got=%0h exp=%0h", F_mem_inst, exp_f); end
  endtask

  task automatic test_reset_mid_wait();
    int spurious;
    resp_en = 1'b0; clear_log();
    Dc_mem_req = 1'b1; Dc_mem_addr = 10'h044;
    @(negedge clk);
    vec++; if (Bk_req !== 1'b1 || Bk_addr !== 10'h044) begin
      err++; $display("FAIL rmw_issue req=%0b addr=%0h exp req=1 addr=44", Bk_req, Bk_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec++; if (Bk_addr !== '0) begin err++; $display("FAIL rmw_async_addr got=%0h exp=0", Bk_addr); end
    vec++; if (MEM_data_line !== '0) begin err++; $display("FAIL rmw_async_line got=%0h exp=0", MEM_data_line); end
    Dc_mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    man_valid = 1'b1; man_rline = {16{8'hC3}};
    @(negedge clk);
    man_valid = 1'b0;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      if (MEM_mem_valid || F_mem_valid || Dc_wb_ack || Bk_req) spurious++;
      @(negedge clk);
    end
    vec++; if (spurious !== 0) begin err++; $display("FAIL rmw_stale_valid got=%0d exp=0", spurious); end
    vec++; if (MEM_data_line !== '0) begin err++; $display("FAIL rmw_mem_line got=%0h exp=0", MEM_data_line); end
    vec++; if (F_mem_inst !== '0) begin err++; $display("FAIL rmw_f_inst got=%0h exp=0", F_mem_inst); end
    exp_f = '0; exp_m = '0;
  endtask

  task automatic test_zero_latency();
    int d_at, i_at;
    logic [LB-1:0] d_data, i_data;
    logic [LA-1:0] ga0, ga1;
    resp_en = 1'b1; bk_lat = 0; bk_data = {16{8'h5A}}; clear_log();
    Dc_mem_req = 1'b1; Dc_mem_addr = 10'h000;
    Ic_mem_req = 1'b1; Ic_mem_addr = 10'h3FF;
    d_at = -1; i_at = -1; d_data = 'x; i_data = 'x;
    for (int i = 1; i <= 20 && (d_at < 0 || i_at < 0); i++) begin
      @(negedge clk);
      if (MEM_mem_valid) begin d_at = i; d_data = MEM_data_line; Dc_mem_req = 1'b0; end
      if (F_mem_valid)   begin i_at = i; i_data = F_mem_inst;    Ic_mem_req = 1'b0; end
    end
    Dc_mem_req = 1'b0; Ic_mem_req = 1'b0;
    vec++; if (d_at !== 2) begin err++; $display("FAIL l0_d_latency got=%0d exp=2", d_at); end
    vec++; if (i_at !== 5) begin err++; $display("FAIL l0_i_latency got=%0d exp=5", i_at); end
    vec++; if (d_data !== {16{8'h5A}}) begin err++; $display("FAIL l0_d_data got=%0h exp=5a..", d_data); end
    vec++; if (i_data !== {16{8'h5A}}) begin err++; $display("FAIL l0_i_data got=%0h exp=5a..", i_data); end
    ga0 = (log_addr.size() > 0) ? log_addr[0] : 'x;
    ga1 = (log_addr.size() > 1) ? log_addr[1] : 'x;
    vec++; if (ga0 !== 10'h000 || ga1 !== 10'h3FF) begin
      err++; $display("FAIL l0_grant_order got=%0h,%0h exp=0,3ff", ga0, ga1);
    end
  endtask

  initial begin
    rst = 1'b1; resp_en = 1'b0; bk_lat = 0; bk_data = '0;
    man_valid = 1'b0; man_rline = '0;
    Ic_mem_req = 1'b0; Ic_mem_addr = '0;
    Dc_mem_req = 1'b0; Dc_mem_addr = '0;
    Dc_wb_we = 1'b0; Dc_wb_addr = '0; Dc_wb_wline = '0;
    test_reset();
    test_ifill();
    test_priority();
    test_round_robin();
    test_wb_capture();
    test_reset_mid_wait();
    test_zero_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
